// File: rtl/bus_rr_scheduler.sv
// Round-robin owner of the shared broadcast bus: pops one packet from the winning
// terminal FIFO, decodes its destination ID and pushes it to one or all other terminals.
module bus_rr_scheduler #(
    parameter int              drvrs     = 4,
    parameter int              pckg_sz   = 16,
    parameter int              id_w      = 8,
    parameter logic [id_w-1:0] broadcast = id_w'(8'hFF)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         D_push,
    output logic [$clog2(drvrs)-1:0]   grant_id,
    output logic                       busy,
    output logic [15:0]                pkt_cnt,
    output logic [15:0]                drop_cnt
);
    // state | meaning
    // IDLE  | no transfer in flight, arbitrating from ptr
    // POP   | pop strobe to granted FIFO, head packet captured
    // PUSH  | packet on the bus to its destination(s), re-arbitrate from grant+1
    localparam int GW = $clog2(drvrs);

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [pckg_sz-1:0]  pkt_q, pkt_d;
    logic [15:0]         pkt_cnt_q, pkt_cnt_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic [id_w-1:0]     id;
    logic [GW-1:0]       next_g;
    logic [drvrs-1:0]    grant_oh;

    function automatic logic [GW-1:0] rr_pick(input logic [drvrs-1:0] req,
                                              input logic [GW-1:0]    start);
        logic found;
        int   idx;
        rr_pick = start;
        found   = 1'b0;
        for (int k = 0; k < drvrs; k++) begin
            idx = (int'(start) + k) % drvrs;
            if (!found && req[idx]) begin
                rr_pick = GW'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            pkt_q      <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            pkt_q      <= pkt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        pkt_d      = pkt_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        pop        = '0;
        push       = '0;
        D_push     = '0;
        id         = pkt_q[pckg_sz-1 -: id_w];
        next_g     = GW'((int'(grant_q) + 1) % drvrs);
        grant_oh   = drvrs'(1) << grant_q;
        case (state_q)
            IDLE: begin
                if (|pndng) begin
                    grant_d = rr_pick(pndng, ptr_q);
                    state_d = POP;
                end
            end
            POP: begin
                pop     = grant_oh;
                pkt_d   = D_pop[int'(grant_q)*pckg_sz +: pckg_sz];
                state_d = PUSH;
            end
            PUSH: begin
                D_push = pkt_q;
                ptr_d  = next_g;
                if (id == broadcast) begin
                    push      = ~grant_oh;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end else if (int'(id) < drvrs && int'(id) != int'(grant_q)) begin
                    push      = drvrs'(1) << id;
                    pkt_cnt_d = pkt_cnt_q + 16'd1;
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
                // Next winner is chosen here so back-to-back packets take two cycles each.
                if (|pndng) begin
                    grant_d = rr_pick(pndng, next_g);
                    state_d = POP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == POP) || (state_q == PUSH);
    assign grant_id = grant_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler: exact-cycle checks of pop/push timing,
// destination decode, round-robin order, reset abort and drop counter saturation.
module tb_bus_rr_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] d_pop;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [15:0] d_push;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bus_rr_scheduler dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push),
        .grant_id (grant_id),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        reset = 1'b1;
        pndng = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (pop !== 4'b0 || push !== 4'b0 || d_push !== 16'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pop=%b push=%b D_push=%h busy=%b want all 0",
                     pop, push, d_push, busy);
        end
        n_checks++;
        if (grant_id !== 2'd0 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got grant=%0d pkt=%0d drop=%0d want 0 0 0",
                     grant_id, pkt_cnt, drop_cnt);
        end
    endtask

    // Called at a negedge with the DUT idle; one packet from src, FIFO empties after the pop.
    task automatic send_one(input int src, input logic [15:0] pkt, input logic [3:0] exp_push,
                            input logic [15:0] exp_pkt, input logic [15:0] exp_drop,
                            input string name);
        logic [3:0] exp_pop;
        exp_pop = 4'b0001 << src;
        pndng[src] = 1'b1;
        d_pop[src*16 +: 16] = pkt;
        @(negedge clk);
        n_checks++;
        if (pop !== exp_pop || grant_id !== 2'(src) || push !== 4'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s pop_cycle: got pop=%b grant=%0d push=%b busy=%b want pop=%b grant=%0d push=0000 busy=1",
                     name, pop, grant_id, push, busy, exp_pop, src);
        end
        pndng[src] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (push !== exp_push || d_push !== pkt || pop !== 4'b0) begin
            n_fail++;
            $display("FAIL %s push_cycle: got push=%b D_push=%h pop=%b want push=%b D_push=%h pop=0000",
                     name, push, d_push, pop, exp_push, pkt);
        end
        d_pop[src*16 +: 16] = 16'hDEAD;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || push !== 4'b0 || d_push !== 16'h0 || pkt_cnt !== exp_pkt
            || drop_cnt !== exp_drop) begin
            n_fail++;
            $display("FAIL %s idle_after: got busy=%b push=%b D_push=%h pkt=%h drop=%h want 0 0000 0000 %h %h",
                     name, busy, push, d_push, pkt_cnt, drop_cnt, exp_pkt, exp_drop);
        end
    endtask

    task automatic test_single_send();
        send_one(0, 16'h02AB, 4'b0100, 16'd1, 16'd0, "single_send");
    endtask

    task automatic test_back_to_back();
        logic [7:0]  seq [4];
        logic [15:0] exp_pkt;
        logic [3:0]  exp_oh;
        int          g;
        int          dst;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i] = 8'(i * 16);
            d_pop[i*16 +: 16] = {8'((i + 1) % 4), seq[i]};
        end
        pndng = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            g      = n % 4;
            dst    = (g + 1) % 4;
            exp_oh = 4'b0001 << g;
            @(negedge clk);
            n_checks++;
            if (pop !== exp_oh || grant_id !== 2'(g)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got pop=%b grant=%0d want pop=%b grant=%0d",
                         n, pop, grant_id, exp_oh, g);
            end
            if (n == 4) pndng = 4'b0000;
            exp_pkt = {8'(dst), seq[g]};
            exp_oh  = 4'b0001 << dst;
            @(negedge clk);
            n_checks++;
            if (push !== exp_oh || d_push !== exp_pkt || pop !== 4'b0) begin
                n_fail++;
                $display("FAIL rr_push_%0d: got push=%b D_push=%h pop=%b want push=%b D_push=%h pop=0000",
                         n, push, d_push, pop, exp_oh, exp_pkt);
            end
            seq[g] = seq[g] + 8'd1;
            d_pop[g*16 +: 16] = {8'(dst), seq[g]};
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || pkt_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL rr_end: got busy=%b pkt=%0d want busy=0 pkt=5", busy, pkt_cnt);
        end
    endtask

    task automatic test_broadcast();
        send_one(2, 16'hFF55, 4'b1011, 16'd6, 16'd0, "broadcast");
    endtask

    task automatic test_drops();
        send_one(1, 16'h0912, 4'b0000, 16'd6, 16'd1, "drop_id9");
        send_one(1, 16'h0134, 4'b0000, 16'd6, 16'd2, "drop_self");
    endtask

    task automatic test_reset_mid_pop();
        pndng[3] = 1'b1;
        d_pop[48 +: 16] = 16'h01AA;
        @(negedge clk);
        n_checks++;
        if (pop !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_pop_setup: got pop=%b want 1000", pop);
        end
        reset = 1'b1;
        pndng = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (pop !== 4'b0 || push !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0
            || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_pop: got pop=%b push=%b busy=%b grant=%0d pkt=%0d drop=%0d want all 0",
                     pop, push, busy, grant_id, pkt_cnt, drop_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (push !== 4'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_lost_pkt: got push=%b busy=%b want 0000 0", push, busy);
        end
        // ptr back at 0 means terminal 1 wins over 2.
        d_pop[16 +: 16] = 16'h0011;
        d_pop[32 +: 16] = 16'h0122;
        pndng = 4'b0110;
        @(negedge clk);
        n_checks++;
        if (pop !== 4'b0010 || grant_id !== 2'd1) begin
            n_fail++;
            $display("FAIL rst_ptr: got pop=%b grant=%0d want pop=0010 grant=1", pop, grant_id);
        end
        pndng = 4'b0100;
        @(negedge clk);
        n_checks++;
        if (push !== 4'b0001 || d_push !== 16'h0011) begin
            n_fail++;
            $display("FAIL rst_push1: got push=%b D_push=%h want 0001 0011", push, d_push);
        end
        @(negedge clk);
        pndng = 4'b0000;
        n_checks++;
        if (pop !== 4'b0100 || grant_id !== 2'd2) begin
            n_fail++;
            $display("FAIL rst_grant2: got pop=%b grant=%0d want 0100 2", pop, grant_id);
        end
        @(negedge clk);
        n_checks++;
        if (push !== 4'b0010 || d_push !== 16'h0122) begin
            n_fail++;
            $display("FAIL rst_push2: got push=%b D_push=%h want 0010 0122", push, d_push);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || pkt_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL rst_after: got busy=%b pkt=%0d want 0 2", busy, pkt_cnt);
        end
    endtask

    task automatic test_drop_saturation();
        force dut.drop_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.drop_cnt_q;
        @(negedge clk);
        n_checks++;
        if (drop_cnt !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_preload: got drop=%h want fffe", drop_cnt);
        end
        send_one(0, 16'h0A00, 4'b0000, 16'd2, 16'hFFFF, "sat_drop1");
        send_one(0, 16'h0A01, 4'b0000, 16'd2, 16'hFFFF, "sat_drop2");
        send_one(0, 16'h0A02, 4'b0000, 16'd2, 16'hFFFF, "sat_drop3");
    endtask

    initial begin
        reset = 1'b1;
        pndng = '0;
        d_pop = '0;
        test_reset();
        test_single_send();
        test_back_to_back();
        test_broadcast();
        test_drops();
        test_reset_mid_pop();
        test_drop_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
